// File: rtl/control_multiplicador_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_multiplicador_pkg                                            |
// | State encoding and operand/product widths for the sequential 4x4     |
// | shift-and-add multiplier.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package control_multiplicador_pkg;

  localparam int WIDTH  = 4;
  localparam int PWIDTH = 2 * WIDTH;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_CHECK = 3'd1;
  localparam logic [2:0] C_ADD   = 3'd2;
  localparam logic [2:0] C_SHIFT = 3'd3;
  localparam logic [2:0] C_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = C_IDLE,
    CHECK = C_CHECK,
    ADD   = C_ADD,
    SHIFT = C_SHIFT,
    DONE  = C_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/control_multiplicador_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_multiplicador_if                                             |
// | Start/done handshake and operand/product bus of the multiplier.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface control_multiplicador_if;
  import control_multiplicador_pkg::*;

  logic              init;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [PWIDTH-1:0] P;
  logic              done;
  logic              busy;

  modport master (output init, A, B, input  P, done, busy);
  modport slave  (input  init, A, B, output P, done, busy);

endinterface
`default_nettype wire

// File: rtl/sumador_8bits_1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sumador_8bits_1                                                      |
// | Structural 8-bit ripple-carry adder built from per-bit full adders.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sumador_8bits_1 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Carry
);

  logic [8:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign S[i]     = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Carry = w_c[8];

endmodule
`default_nettype wire

// File: rtl/control_multiplicador.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_multiplicador                                                |
// | Sequential 4x4 shift-and-add multiplier sharing one 8-bit adder.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module control_multiplicador
  import control_multiplicador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  control_multiplicador_if.slave bus
);

  // The shared adder is fixed at 8 bits, so only 4-bit operands fit.
  if (WIDTH != 4 || WIDTH != control_multiplicador_pkg::WIDTH) begin : g_bad_width
    $error("control_multiplicador: WIDTH must be 4");
  end

  state_t            r_state;
  state_t            w_next;
  logic              w_busy;
  logic              w_done;

  logic [PWIDTH-1:0] r_md;
  logic [WIDTH-1:0]  r_mr;
  logic [PWIDTH-1:0] r_acc;
  logic [1:0]        r_cnt;
  logic [PWIDTH-1:0] r_p;
  logic [PWIDTH-1:0] w_sum;
  logic              w_unused_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = (r_state != IDLE);
    w_done = (r_state == DONE);
    case (r_state)
      IDLE:    if (bus.init) w_next = CHECK;
      CHECK:   w_next = r_mr[0] ? ADD : SHIFT;
      ADD:     w_next = SHIFT;
      SHIFT:   w_next = (r_cnt == 2'd3) ? DONE : CHECK;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_md  <= '0;
      r_mr  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.init) begin
            r_md  <= {{(PWIDTH-WIDTH){1'b0}}, bus.A};
            r_mr  <= bus.B;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ADD: r_acc <= w_sum;
        SHIFT: begin
          r_md  <= r_md << 1;
          r_mr  <= r_mr >> 1;
          r_cnt <= r_cnt + 2'd1;
          // Last multiplier bit consumed: publish the accumulated product.
          if (r_cnt == 2'd3) r_p <= r_acc;
        end
        default: ;
      endcase
    end
  end

  // Max product is 225, so the carry out never carries information.
  sumador_8bits_1 u_add (
    .A     (r_acc),
    .B     (r_md),
    .Cin   (1'b0),
    .S     (w_sum),
    .Carry (w_unused_carry)
  );

  assign bus.P    = r_p;
  assign bus.done = w_done;
  assign bus.busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_control_multiplicador.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_multiplicador                                             |
// | Scoreboard bench: expected product/latency queued at start, checked  |
// | on every done pulse; P is checked for stability every cycle.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_control_multiplicador;
  import control_multiplicador_pkg::*;

  typedef struct {
    logic [PWIDTH-1:0] p;
    int                lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  control_multiplicador_if bus ();

  control_multiplicador #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t              q[$];
  int                rd        = 0;
  int                n_vec     = 0;
  int                n_err     = 0;
  int                cyc       = 0;
  int                start     = 0;
  logic              prev_busy = 1'b0;
  logic [PWIDTH-1:0] model_p   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (bus.done) begin
      chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
      if (rd < q.size()) begin
        chk("product", {24'd0, bus.P}, {24'd0, q[rd].p});
        chk("latency", cyc - start, q[rd].lat);
        model_p = q[rd].p;
        rd++;
      end else begin
        chk("spurious_done", {31'd0, bus.done}, 32'd0);
      end
    end else begin
      chk("p_hold", {24'd0, bus.P}, {24'd0, model_p});
    end
    if (bus.busy && !prev_busy) start = cyc;
    prev_busy = bus.busy;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push_exp(input int a, input int b);
    logic [3:0] bb;
    bb = b[3:0];
    q.push_back('{p: PWIDTH'(a * b), lat: 8 + $countones(bb)});
  endtask

  task automatic start_op(input int a, input int b);
    bus.A    = a[3:0];
    bus.B    = b[3:0];
    bus.init = 1'b1;
    push_exp(a, b);
    tick();
    bus.init = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (rd < q.size() && n < bound) begin
      tick();
      n++;
    end
    chk("drain", rd, q.size());
  endtask

  task automatic post_reset_checks(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_p"},    {24'd0, bus.P},    32'd0);
  endtask

  initial begin
    bus.init = 1'b0;
    bus.A    = '0;
    bus.B    = '0;

    // Power-up reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    post_reset_checks("reset");

    // Reset and init on the same edge: reset wins.
    bus.A    = 4'd5;
    bus.B    = 4'd5;
    rst      = 1'b1;
    bus.init = 1'b1;
    tick();
    rst      = 1'b0;
    bus.init = 1'b0;
    post_reset_checks("rst_init");
    repeat (14) tick();

    // Directed products.
    start_op(3, 5);
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    wait_idle(40);
    start_op(15, 15);
    wait_idle(40);
    start_op(0, 9);
    wait_idle(40);
    start_op(7, 0);
    wait_idle(40);

    // Exhaustive, back-to-back with init held high.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] bb;
        bb       = b[3:0];
        bus.A    = a[3:0];
        bus.B    = bb;
        bus.init = 1'b1;
        push_exp(a, b);
        repeat (8 + $countones(bb) + 2) tick();
      end
    end
    bus.init = 1'b0;
    wait_idle(40);

    // Operand changes and init pulses while busy are ignored.
    start_op(6, 7);
    bus.A = 4'd1;
    bus.B = 4'd1;
    repeat (3) tick();
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    repeat (7) tick();
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    wait_idle(40);
    repeat (16) tick();

    // Reset mid-operation discards the partial result.
    start_op(9, 11);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    model_p = '0;
    rd      = q.size();
    post_reset_checks("mid_rst");
    repeat (20) tick();
    start_op(2, 3);
    wait_idle(40);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
